// File: rtl/musb_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// musb_muldiv_pkg
// Shared definitions for the MUSB multiply/divide unit.
//   - op_sel_t : one-hot-free encoding of the operation picked from the
//                individual op_* request lines after priority resolution.
//   - decode_op: priority encoder turning the eight op_* lines into op_sel_t.
//                Priority: div > divu > mult > multu > mthi > mtlo > mfhi > mflo.
// -----------------------------------------------------------------------------
package musb_muldiv_pkg;

    localparam int DATA_W = 32;
    localparam int MUL_W  = 33;   // operand width after sign/zero extension
    localparam int PROD_W = 64;   // retained product width

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_DIV   = 4'd1,
        OP_DIVU  = 4'd2,
        OP_MULT  = 4'd3,
        OP_MULTU = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } op_sel_t;

    function automatic op_sel_t decode_op(
        input logic div,
        input logic divu,
        input logic mult,
        input logic multu,
        input logic mthi,
        input logic mtlo,
        input logic mfhi,
        input logic mflo
    );
        op_sel_t sel;
        sel = OP_NONE;
        if (div)        sel = OP_DIV;
        else if (divu)  sel = OP_DIVU;
        else if (mult)  sel = OP_MULT;
        else if (multu) sel = OP_MULTU;
        else if (mthi)  sel = OP_MTHI;
        else if (mtlo)  sel = OP_MTLO;
        else if (mfhi)  sel = OP_MFHI;
        else if (mflo)  sel = OP_MFLO;
        return sel;
    endfunction

endpackage

// File: rtl/musb_div.sv
// -----------------------------------------------------------------------------
// musb_div
// Sequential restoring divider, one quotient bit per clock, 32 iterations.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset (aborts any division)
//   op_divs       : one-cycle start pulse, signed divide
//   op_divu       : one-cycle start pulse, unsigned divide
//   dividend      : 32-bit dividend, sampled on the start cycle only
//   divisor       : 32-bit divisor, sampled on the start cycle only
//   quotient      : 32-bit quotient, sign-corrected for signed divides
//   remainder     : 32-bit remainder MAGNITUDE (caller applies dividend sign)
//   stall         : 1 while iterating; first 0 after a start marks completion
//
// Timing: start sampled at the edge ending cycle T0, stall = 1 in T1..T32,
// stall = 0 in T33 with quotient/remainder valid.
//
// Signed divides work on magnitudes; only the quotient is re-signed here.
// Divide by zero needs no special case: every trial subtraction of 0 fits,
// giving an all-ones quotient and the dividend as remainder.
// -----------------------------------------------------------------------------
module musb_div
    import musb_muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              op_divs,
    input  logic              op_divu,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              stall
);

    logic              active;
    logic [4:0]        count;
    logic [DATA_W-1:0] dvd_q;     // dividend bits still to be shifted in
    logic [DATA_W-1:0] dvs_q;     // divisor magnitude
    logic [DATA_W-1:0] quo_q;     // quotient magnitude being built
    logic [DATA_W-1:0] rem_q;     // partial remainder
    logic              neg_q;     // quotient must be negated at the end

    logic              start;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W:0]   trial;
    logic              fits;
    logic [DATA_W-1:0] rem_sub;

    assign start = op_divs | op_divu;
    assign a_neg = op_divs & dividend[DATA_W-1];
    assign b_neg = op_divs & divisor[DATA_W-1];
    assign a_mag = a_neg ? (32'd0 - dividend) : dividend;
    assign b_mag = b_neg ? (32'd0 - divisor)  : divisor;

    // Partial remainder shifted left with the next dividend bit appended.
    assign trial = {rem_q, dvd_q[DATA_W-1]};
    assign fits  = (trial >= {1'b0, dvs_q});
    // When the divisor fits, the true difference is below 2^32, so the low
    // 32 bits of the subtraction are exact.
    assign rem_sub = trial[DATA_W-1:0] - dvs_q;

    assign stall     = active;
    assign quotient  = neg_q ? (32'd0 - quo_q) : quo_q;
    assign remainder = rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            count  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            neg_q  <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            count  <= '0;
            dvd_q  <= a_mag;
            dvs_q  <= b_mag;
            quo_q  <= '0;
            rem_q  <= '0;
            neg_q  <= a_neg ^ b_neg;
        end else if (active) begin
            dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
            quo_q <= {quo_q[DATA_W-2:0], fits};
            rem_q <= fits ? rem_sub : trial[DATA_W-1:0];
            count <= count + 5'd1;
            if (count == 5'd31) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/musb_muldiv.sv
// -----------------------------------------------------------------------------
// musb_muldiv
// HI/LO multiply/divide unit for the MUSB core.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   op_div, op_divu   : start signed / unsigned divide (one accepted cycle)
//   op_mult, op_multu : start signed / unsigned multiply (one accepted cycle)
//   op_mthi, op_mtlo  : write input_a into HI / LO
//   op_mfhi, op_mflo  : drive HI / LO onto result
//   input_a, input_b  : operands (sampled only in the issue cycle)
//   result            : HI or LO for an accepted MF op, else 0 (combinational)
//   hi, lo            : architectural HI / LO registers
//   stall             : 1 when an op is requested but the unit is busy
//   debug_state       : current FSM state encoding
//
// Valid/ready: any op_* line high is a request; it is accepted in the same
// cycle when stall = 0 (unit IDLE). A stalled request has no side effects and
// must be held by the requester until stall drops.
//
// Multiply: issue T0 registers extended operands, MUL1 (T1) registers the
// product, MUL2 (T2) writes HI/LO. Divide: issue T0 pulses the divider,
// DIV_WAIT writes HI/LO on the first cycle the divider stops stalling.
// -----------------------------------------------------------------------------
module musb_muldiv
    import musb_muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              op_div,
    input  logic              op_divu,
    input  logic              op_mult,
    input  logic              op_multu,
    input  logic              op_mthi,
    input  logic              op_mtlo,
    input  logic              op_mfhi,
    input  logic              op_mflo,
    input  logic [DATA_W-1:0] input_a,
    input  logic [DATA_W-1:0] input_b,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              stall,
    output logic [1:0]        debug_state
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MUL1     = 2'd1;
    localparam logic [1:0] ST_MUL2     = 2'd2;
    localparam logic [1:0] ST_DIV_WAIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        MUL1     = ST_MUL1,
        MUL2     = ST_MUL2,
        DIV_WAIT = ST_DIV_WAIT
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [MUL_W-1:0]  op_a_q;
    logic [MUL_W-1:0]  op_b_q;
    logic [PROD_W-1:0] product_q;
    logic              div_neg_q;   // dividend sign of the running signed divide

    op_sel_t           sel;
    logic              idle;
    logic              op_any;
    logic              div_start_s;
    logic              div_start_u;
    logic [PROD_W-1:0] prod;

    logic [DATA_W-1:0] div_quotient;
    logic [DATA_W-1:0] div_remainder;
    logic              div_stall;

    assign sel = decode_op(op_div, op_divu, op_mult, op_multu,
                           op_mthi, op_mtlo, op_mfhi, op_mflo);

    assign idle        = (state == IDLE);
    assign op_any      = (sel != OP_NONE);
    assign stall       = !idle && op_any;
    assign div_start_s = idle && (sel == OP_DIV);
    assign div_start_u = idle && (sel == OP_DIVU);

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign debug_state = state;

    // 33x33 signed product: sign-extending both operands to 64 bits and
    // multiplying modulo 2^64 yields exactly the low 64 product bits.
    assign prod = {{(PROD_W-MUL_W){op_a_q[MUL_W-1]}}, op_a_q}
                * {{(PROD_W-MUL_W){op_b_q[MUL_W-1]}}, op_b_q};

    // MF reads see the register value at the start of the cycle; a write
    // landing on the same edge is not forwarded.
    always_comb begin
        result = '0;
        if (idle) begin
            case (sel)
                OP_MFHI: result = hi_q;
                OP_MFLO: result = lo_q;
                default: result = '0;
            endcase
        end
    end

    musb_div u_div (
        .clk       (clk),
        .rst       (rst),
        .op_divs   (div_start_s),
        .op_divu   (div_start_u),
        .dividend  (input_a),
        .divisor   (input_b),
        .quotient  (div_quotient),
        .remainder (div_remainder),
        .stall     (div_stall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            product_q <= '0;
            div_neg_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    case (sel)
                        OP_DIV: begin
                            div_neg_q <= input_a[DATA_W-1];
                            state     <= DIV_WAIT;
                        end
                        OP_DIVU: begin
                            div_neg_q <= 1'b0;
                            state     <= DIV_WAIT;
                        end
                        OP_MULT: begin
                            op_a_q <= {input_a[DATA_W-1], input_a};
                            op_b_q <= {input_b[DATA_W-1], input_b};
                            state  <= MUL1;
                        end
                        OP_MULTU: begin
                            op_a_q <= {1'b0, input_a};
                            op_b_q <= {1'b0, input_b};
                            state  <= MUL1;
                        end
                        OP_MTHI: hi_q <= input_a;
                        OP_MTLO: lo_q <= input_a;
                        default: ;
                    endcase
                end
                MUL1: begin
                    product_q <= prod;
                    state     <= MUL2;
                end
                MUL2: begin
                    hi_q  <= product_q[PROD_W-1:DATA_W];
                    lo_q  <= product_q[DATA_W-1:0];
                    state <= IDLE;
                end
                DIV_WAIT: begin
                    if (!div_stall) begin
                        lo_q  <= div_quotient;
                        // Remainder follows the dividend's sign.
                        hi_q  <= div_neg_q ? (32'd0 - div_remainder) : div_remainder;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_musb_muldiv.sv
// -----------------------------------------------------------------------------
// tb_musb_muldiv
// Directed bench for musb_muldiv. Inputs change 1 time unit after the rising
// edge; outputs are sampled 2 units after it.
// -----------------------------------------------------------------------------
module tb_musb_muldiv;

    logic        clk;
    logic        rst;
    logic        op_div, op_divu, op_mult, op_multu;
    logic        op_mthi, op_mtlo, op_mfhi, op_mflo;
    logic [31:0] input_a, input_b;
    logic [31:0] result, hi, lo;
    logic        stall;
    logic [1:0]  debug_state;

    int n_checks = 0;
    int n_fail   = 0;

    musb_muldiv dut (
        .clk         (clk),
        .rst         (rst),
        .op_div      (op_div),
        .op_divu     (op_divu),
        .op_mult     (op_mult),
        .op_multu    (op_multu),
        .op_mthi     (op_mthi),
        .op_mtlo     (op_mtlo),
        .op_mfhi     (op_mfhi),
        .op_mflo     (op_mflo),
        .input_a     (input_a),
        .input_b     (input_b),
        .result      (result),
        .hi          (hi),
        .lo          (lo),
        .stall       (stall),
        .debug_state (debug_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ops();
        op_div   = 1'b0; op_divu  = 1'b0; op_mult = 1'b0; op_multu = 1'b0;
        op_mthi  = 1'b0; op_mtlo  = 1'b0; op_mfhi = 1'b0; op_mflo  = 1'b0;
    endtask

    // Multiply: busy cycles hold an MTHI request with junk data; HI must stay
    // at prev_hi through T2 and show the product in T3.
    task automatic run_mul(input logic is_signed, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input logic [31:0] prev_hi, input string tag);
        step(); clear_ops();
        if (is_signed) op_mult = 1'b1; else op_multu = 1'b1;
        input_a = a; input_b = b;
        #1;
        check({tag, " T0 stall"}, {31'd0, stall}, 32'd0);
        for (int t = 1; t <= 2; t++) begin
            step(); clear_ops();
            op_mthi = 1'b1; input_a = $urandom; input_b = $urandom;
            #1;
            check({tag, " busy stall"}, {31'd0, stall}, 32'd1);
            check({tag, " busy hi"}, hi, prev_hi);
        end
        step(); clear_ops();
        op_mfhi = 1'b1;
        #1;
        check({tag, " T3 stall"}, {31'd0, stall}, 32'd0);
        check({tag, " T3 result"}, result, exp_hi);
        check({tag, " T3 lo"}, lo, exp_lo);
    endtask

    // Divide: T0 also raises op_mflo (divide wins, result 0); T1..T33 hold
    // op_mflo with junk operands; T34 reads LO.
    task automatic run_div(input logic is_signed, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input string tag);
        step(); clear_ops();
        if (is_signed) op_div = 1'b1; else op_divu = 1'b1;
        op_mflo = 1'b1;
        input_a = a; input_b = b;
        #1;
        check({tag, " T0 stall"}, {31'd0, stall}, 32'd0);
        check({tag, " T0 result"}, result, 32'd0);
        for (int t = 1; t <= 33; t++) begin
            step(); clear_ops();
            op_mflo = 1'b1; input_a = $urandom; input_b = $urandom;
            #1;
            check({tag, " wait stall"}, {31'd0, stall}, 32'd1);
        end
        step(); clear_ops();
        op_mflo = 1'b1;
        #1;
        check({tag, " T34 stall"}, {31'd0, stall}, 32'd0);
        check({tag, " T34 result"}, result, exp_lo);
        check({tag, " T34 lo"}, lo, exp_lo);
        check({tag, " T34 hi"}, hi, exp_hi);
    endtask

    initial begin
        clear_ops();
        rst = 1'b1;
        input_a = '0;
        input_b = '0;

        // reset state
        step(); step();
        rst = 1'b0;
        op_mflo = 1'b1;
        #1;
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset result", result, 32'd0);
        check("reset state", {30'd0, debug_state}, 32'd0);

        // MTHI then MFHI next cycle
        step(); clear_ops();
        op_mthi = 1'b1; input_a = 32'hA5A5A5A5;
        #1;
        check("mthi stall", {31'd0, stall}, 32'd0);
        step(); clear_ops();
        op_mfhi = 1'b1; input_a = 32'h0;
        #1;
        check("mfhi result", result, 32'hA5A5A5A5);
        check("mfhi stall", {31'd0, stall}, 32'd0);

        // MTLO then MFLO
        step(); clear_ops();
        op_mtlo = 1'b1; input_a = 32'h5A5A5A5A;
        #1;
        step(); clear_ops();
        op_mflo = 1'b1;
        #1;
        check("mflo result", result, 32'h5A5A5A5A);

        // MTHI beats MTLO; MFHI beats MFLO
        step(); clear_ops();
        op_mthi = 1'b1; op_mtlo = 1'b1; input_a = 32'h11111111;
        #1;
        step(); clear_ops();
        op_mfhi = 1'b1; op_mflo = 1'b1;
        #1;
        check("prio mfhi result", result, 32'h11111111);
        check("prio lo kept", lo, 32'h5A5A5A5A);

        // multiplies
        run_mul(1'b1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h11111111, "mult m1x2");
        run_mul(1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, "multu m1x2");
        run_mul(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, "multu max");

        // divides
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "divu 100/7");
        run_div(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, "div -100/7");
        run_div(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, "div 100/-7");
        run_div(1'b0, 32'h00001234, 32'd0, 32'hFFFFFFFF, 32'h00001234, "divu by 0");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, "div min/-1");

        // reset in the middle of a divide
        step(); clear_ops();
        op_div = 1'b1; input_a = 32'd1000; input_b = 32'd3;
        #1;
        for (int t = 1; t <= 9; t++) begin
            step(); clear_ops();
            op_mflo = 1'b1;
            #1;
            check("abort wait stall", {31'd0, stall}, 32'd1);
        end
        step(); clear_ops();
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        op_mflo = 1'b1;
        #1;
        check("abort stall", {31'd0, stall}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        check("abort result", result, 32'd0);
        run_mul(1'b1, 32'd3, 32'd4, 32'd0, 32'd12, 32'd0, "mult 3x4");
        run_div(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, "divu after rst");

        step(); clear_ops();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/musb_muldiv.md
MUSB_MULDIV -- requirements
Module: musb_muldiv

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 op_div, op_divu, op_mult, op_multu  input  1 each  start signed/unsigned divide or multiply; valid for one accepted cycle.
REQ-004 op_mthi, op_mtlo  input  1 each  write input_a to HI/LO.
REQ-005 op_mfhi, op_mflo  input  1 each  read HI/LO onto result.
REQ-006 input_a  input  32  dividend / multiplicand / MT data.
REQ-007 input_b  input  32  divisor / multiplier.
REQ-008 result  output  32  HI (op_mfhi) or LO (op_mflo), else 0; combinational.
REQ-009 hi, lo  output  32 each  architectural HI/LO registers.
REQ-010 stall  output  1  combinational; 1 = current muldiv/MT/MF op not accepted this cycle.

Function
REQ-011 FSM states: IDLE, MUL1, MUL2, DIV_WAIT; encodings 2-bit localparams.
REQ-012 Op accepted only in IDLE; if several op_* high, priority div > divu > mult > multu > mthi > mtlo > mfhi > mflo.
REQ-013 stall = (state != IDLE) & (any op_* high); stall = 0 in IDLE.
REQ-014 MTHI/MTLO in IDLE: HI/LO = input_a at the edge ending the issue cycle; no state change.
REQ-015 MFHI/MFLO in IDLE: result = current hi/lo same cycle; a write from the same edge is not bypassed.
REQ-016 MULT/MULTU issue (T0): register operands sign- (MULT) or zero- (MULTU) extended to 33 bits; state -> MUL1.
REQ-017 MUL1 (T1): register 64-bit product of the 33x33 operands, lower 64 bits; state -> MUL2.
REQ-018 MUL2 (T2): HI = product[63:32], LO = product[31:0]; state -> IDLE; first accepting cycle T3.
REQ-019 DIV/DIVU issue (T0): pulse op_divs/op_divu of sub-divider for exactly one cycle with input_a/input_b; latch dividend sign (signed only); state -> DIV_WAIT.
REQ-020 DIV_WAIT: remain while sub-divider stall = 1; first cycle with sub-divider stall = 0 (T33): LO = quotient, HI = remainder, state -> IDLE; first accepting cycle T34.
REQ-021 Signed remainder: HI = negated divider remainder when latched dividend sign = 1, else unchanged (remainder takes dividend sign).
REQ-022 Divide by zero: no exception; DIVU result LO = 0xFFFFFFFF, HI = dividend; DIV per the same datapath plus REQ-021.
REQ-023 0x80000000 / -1 signed: LO = 0x80000000, HI = 0; no exception.
REQ-024 Operand inputs ignored outside issue cycle; changes during MUL1/MUL2/DIV_WAIT do not affect the result.
REQ-025 HI/LO unchanged by a stalled op.

Reset
REQ-026 rst: state = IDLE, hi = lo = 0, product/operand registers = 0, sub-divider reset; stall = 0 the cycle after.
REQ-027 rst mid-operation (any state) aborts it; no HI/LO write from the aborted op.

Structure
REQ-028 One sub-module: musb_div (existing sequential divider), driven by rst, one-cycle start pulses; its stall output is the only completion indicator.
REQ-029 FSM encodings local to module; op-select constants in the shared MUSB defines header.
REQ-030 Multiplier is one registered 33x33 stage; no other sub-modules.

Verification
REQ-031 DIVU 100/7, then op_mflo held high -> stall 1 through T33, LO = 14, HI = 2; result = 14 in T34.
REQ-032 DIV 0xFFFFFF9C(-100)/7 -> LO = 0xFFFFFFF2, HI = 0xFFFFFFFE.
REQ-033 MULT 0xFFFFFFFF*2 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFE; MULTU same operands -> HI = 0x00000001, LO = 0xFFFFFFFE; both written at end of T2.
REQ-034 DIVU 0x1234/0 -> LO = 0xFFFFFFFF, HI = 0x1234, no hang.
REQ-035 DIV started, rst at T10 -> T11 stall = 0, hi = lo = 0; new MULT 3*4 -> LO = 12, HI = 0.
REQ-036 MTHI 0xA5A5A5A5 at T0, MFHI at T1 -> result = 0xA5A5A5A5 in T1, stall = 0.
